// File: rtl/bist_pkg.sv
// Shared types and constants for the 4-bit BIST controller.
// Covers FSM states, datapath width and the x^4+x^3+1 feedback taps.
package bist_pkg;

  localparam int WIDTH = 4;

  localparam logic [WIDTH-1:0] TAPS = 4'b1100;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/bist_lfsr4.sv
// 4-bit shift/feedback register with load, enable and parallel XOR.
// Serves as TPG (par_i tied low) or as MISR (par_i = CUT response).
module bist_lfsr4
  import bist_pkg::*;
#(
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             fb;

  assign fb = ^(q_q & TAPS);

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = {q_q[WIDTH-2:0], fb} ^ par_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer for the CUT input mux: drives the TPG,
// compacts responses in a MISR and reports done/pass.
module bist_controller
  import bist_pkg::*;
#(
  parameter int               NUM_PATTERNS = 15,
  parameter logic [WIDTH-1:0] LFSR_SEED    = 4'b0001,
  parameter logic [WIDTH-1:0] GOLDEN_SIG   = 4'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cut_resp,
  output logic             test_mode,
  output logic [WIDTH-1:0] test_pattern,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PATTERNS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic             idle_or_done;
  logic             in_run_phase;
  logic             launch;
  logic             run_en;
  logic [WIDTH-1:0] misr;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign in_run_phase = (state_q == INIT) || (state_q == RUN)
                     || (state_q == CHECK);

  // Both registers are (re)loaded on the very edge that enters INIT.
  assign launch = idle_or_done && start && !abort;
  assign run_en = (state_q == RUN) && !abort;

  bist_lfsr4 #(
    .RST_VAL(LFSR_SEED)
  ) u_tpg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (launch),
    .load_val_i(LFSR_SEED),
    .en_i      (run_en),
    .par_i     ('0),
    .q_o       (test_pattern)
  );

  bist_lfsr4 #(
    .RST_VAL('0)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (launch),
    .load_val_i('0),
    .en_i      (run_en),
    .par_i     (cut_resp),
    .q_o       (misr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (abort && in_run_phase) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (launch) begin
            state_q <= INIT;
            cnt_q   <= '0;
            mode_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        INIT: begin
          state_q <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= CHECK;
            mode_q  <= 1'b0;
          end
        end
        CHECK: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (misr == GOLDEN_SIG);
        end
        default: begin
          state_q <= IDLE;
          mode_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign test_mode = mode_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr;

endmodule

// File: tb/tb_bist_controller.sv
// Directed + randomized bench for bist_controller.
// Reference: spec pattern table and MISR fold over collected responses.
module tb_bist_controller;

  localparam int         N      = 15;
  localparam logic [3:0] SEED   = 4'b0001;
  localparam logic [3:0] GOLDEN = 4'h0;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] cut_resp;
  logic       test_mode;
  logic [3:0] test_pattern;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] signature;

  logic       mux_sel;
  logic [3:0] resp_drv;

  int checks;
  int errors;

  logic [3:0] pats [N];

  // mux_sel=1 models the CUT seeing the mux output (b side in test mode)
  assign cut_resp = mux_sel ? (test_mode ? test_pattern : 4'h0) : resp_drv;

  bist_controller #(
    .NUM_PATTERNS(N),
    .LFSR_SEED   (SEED),
    .GOLDEN_SIG  (GOLDEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cut_resp    (cut_resp),
    .test_mode   (test_mode),
    .test_pattern(test_pattern),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .signature   (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] misr_fold(logic [3:0] m, logic [3:0] r);
    return {m[2:0], m[3] ^ m[2]} ^ r;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"}, test_mode, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_sig"}, signature, 4'h0);
    check({tag, "_pat"}, test_pattern, SEED);
  endtask

  // kind: 0 zeros, 1 single 1 in first RUN cycle, 2 mux output, 3 random
  task automatic run(input string tag, input int kind, input bit hold);
    logic [3:0] sig;
    logic [3:0] r;
    sig = 4'h0;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    check({tag, "_init_mode"}, test_mode, 1'b1);
    check({tag, "_init_busy"}, busy, 1'b1);
    check({tag, "_init_done"}, done, 1'b0);
    check({tag, "_init_pat"}, test_pattern, SEED);
    tick();
    for (int i = 0; i < N; i++) begin
      check({tag, "_run_pat"}, test_pattern, pats[i % 15]);
      check({tag, "_run_mode"}, test_mode, 1'b1);
      check({tag, "_run_done"}, done, 1'b0);
      case (kind)
        0: r = 4'h0;
        1: r = (i == 0) ? 4'h1 : 4'h0;
        2: r = pats[i % 15];
        default: r = 4'($urandom_range(15, 0));
      endcase
      mux_sel  = (kind == 2);
      resp_drv = (kind == 2) ? 4'h0 : r;
      sig      = misr_fold(sig, r);
      tick();
    end
    mux_sel  = 1'b0;
    resp_drv = 4'h0;
    check({tag, "_chk_mode"}, test_mode, 1'b0);
    check({tag, "_chk_busy"}, busy, 1'b1);
    check({tag, "_chk_done"}, done, 1'b0);
    tick();
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_mode"}, test_mode, 1'b0);
    check({tag, "_pass"}, pass, (sig == GOLDEN));
    check({tag, "_sig"}, signature, sig);
  endtask

  initial begin
    logic [3:0] sig;
    logic [3:0] r;
    pats = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    mux_sel  = 1'b0;
    resp_drv = 4'h0;
    tick();
    tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    check_reset_vals("idle");

    // async reset in the middle of RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    resp_drv = 4'h5;
    tick();
    check("mid_mode", test_mode, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    resp_drv = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();

    run("zero", 0, 1'b0);
    check("zero_sig_is0", signature, 4'h0);
    repeat (2) tick();
    check("done_hold", done, 1'b1);
    check("pass_hold", pass, 1'b1);

    run("one", 1, 1'b0);
    check("one_sig_8", signature, 4'h8);

    run("mux", 2, 1'b0);

    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(3, 0)) tick();
      run("rand", 3, 1'b0);
    end

    // abort in the 5th RUN cycle; signature holds its partial value
    sig   = 4'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      r        = 4'($urandom_range(15, 0));
      resp_drv = r;
      sig      = misr_fold(sig, r);
      tick();
    end
    check("ab_pat5", test_pattern, pats[4]);
    abort    = 1'b1;
    resp_drv = 4'h7;
    tick();
    abort    = 1'b0;
    resp_drv = 4'h0;
    check("ab_mode", test_mode, 1'b0);
    check("ab_busy", busy, 1'b0);
    check("ab_done", done, 1'b0);
    check("ab_pass", pass, 1'b0);
    check("ab_sig", signature, sig);
    tick();
    check("ab_idle_busy", busy, 1'b0);
    run("after_ab", 3, 1'b0);

    // start held: one DONE cycle, then a fresh INIT
    run("held", 0, 1'b1);
    tick();
    check("held_done_drop", done, 1'b0);
    check("held_pass_drop", pass, 1'b0);
    check("held_busy", busy, 1'b1);
    check("held_mode", test_mode, 1'b1);
    check("held_pat", test_pattern, SEED);
    abort = 1'b1;
    start = 1'b0;
    tick();
    abort = 1'b0;
    check("held_ab_busy", busy, 1'b0);

    // start with abort in IDLE never launches
    start = 1'b1;
    abort = 1'b1;
    tick();
    check("sa_busy", busy, 1'b0);
    check("sa_mode", test_mode, 1'b0);
    tick();
    check("sa_busy2", busy, 1'b0);
    check("sa_done", done, 1'b0);
    start = 1'b0;
    abort = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
